// File: rtl/or1200_ld_resp_sequencer_pkg.sv
// rtl/or1200_ld_resp_sequencer_pkg.sv - shared types for the load response sequencer
package or1200_ld_resp_sequencer_pkg;

  // Response FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    OR1200_LDSEQ_IDLE = 2'd0,
    OR1200_LDSEQ_TAG  = 2'd1,
    OR1200_LDSEQ_DEC  = 2'd2,
    OR1200_LDSEQ_OUT  = 2'd3
  } ldseq_state_e;

endpackage

// File: rtl/or1200_ld_resp_sequencer.sv
// rtl/or1200_ld_resp_sequencer.sv - tag FIFO reader routing load data to writeback or decryption
module or1200_ld_resp_sequencer
  import or1200_ld_resp_sequencer_pkg::*;
#(
  parameter int aw = 4,
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_issue,
  output logic          fifo_ce_r,
  input  logic          fifo_secure,
  input  logic          mem_ack,
  input  logic [dw-1:0] mem_dat,
  output logic          mem_stall,
  output logic          dec_req,
  output logic [dw-1:0] dec_dat_o,
  input  logic          dec_ack,
  input  logic [dw-1:0] dec_dat_i,
  output logic          wb_valid,
  output logic [dw-1:0] wb_dat,
  output logic          wb_secure,
  output logic [aw:0]   outstanding,
  output logic          full,
  output logic          err
);

  localparam logic [aw:0] depth   = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] cnt_one = {{aw{1'b0}}, 1'b1};

  ldseq_state_e  state_q, state_d;
  logic [dw-1:0] data_q;
  logic          sec_q;
  logic          has_tag;

  assign has_tag   = (outstanding != '0);
  assign full      = (outstanding == depth);
  // Ciphertext is the captured load data; only meaningful while dec_req is high
  assign dec_dat_o = data_q;

  // Next-state and strobe decode; all handshake outputs derive from the current state
  always_comb begin
    state_d   = state_q;
    fifo_ce_r = 1'b0;
    mem_stall = 1'b1;
    dec_req   = 1'b0;
    wb_valid  = 1'b0;
    wb_secure = 1'b0;
    case (state_q)
      OR1200_LDSEQ_IDLE: begin
        mem_stall = 1'b0;
        if (mem_ack && has_tag) begin
          fifo_ce_r = 1'b1;
          state_d   = OR1200_LDSEQ_TAG;
        end
      end
      OR1200_LDSEQ_TAG: begin
        state_d = fifo_secure ? OR1200_LDSEQ_DEC : OR1200_LDSEQ_OUT;
      end
      OR1200_LDSEQ_DEC: begin
        dec_req = 1'b1;
        if (dec_ack) state_d = OR1200_LDSEQ_OUT;
      end
      OR1200_LDSEQ_OUT: begin
        wb_valid  = 1'b1;
        wb_secure = sec_q;
        state_d   = OR1200_LDSEQ_IDLE;
      end
      default: state_d = OR1200_LDSEQ_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight decryption request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OR1200_LDSEQ_IDLE;
    else      state_q <= state_d;
  end

  // Load data capture, tag capture and writeback data selection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      sec_q  <= 1'b0;
      wb_dat <= '0;
    end else begin
      if (fifo_ce_r) data_q <= mem_dat;
      if (state_q == OR1200_LDSEQ_TAG) begin
        sec_q <= fifo_secure;
        if (!fifo_secure) wb_dat <= data_q;
      end
      if (state_q == OR1200_LDSEQ_DEC && dec_ack) wb_dat <= dec_dat_i;
    end
  end

  // Occupancy counter: saturates at depth, never underflows since pops require a tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else if (ld_issue && !fifo_ce_r && !full) begin
      outstanding <= outstanding + cnt_one;
    end else if (fifo_ce_r && !ld_issue) begin
      outstanding <= outstanding - cnt_one;
    end
  end

  // Sticky protocol error: overflow, ack with nothing outstanding, ack while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((ld_issue && full && !fifo_ce_r) ||
                 (mem_ack && mem_stall) ||
                 (mem_ack && !mem_stall && !has_tag)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_or1200_ld_resp_sequencer.sv
// tb/tb_or1200_ld_resp_sequencer.sv - directed vector bench for the load response sequencer
module tb_or1200_ld_resp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_issue = 1'b0;
  logic        fifo_ce_r;
  logic        fifo_secure = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dat = '0;
  logic        mem_stall;
  logic        dec_req;
  logic [31:0] dec_dat_o;
  logic        dec_ack = 1'b0;
  logic [31:0] dec_dat_i = '0;
  logic        wb_valid;
  logic [31:0] wb_dat;
  logic        wb_secure;
  logic [4:0]  outstanding;
  logic        full;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  or1200_ld_resp_sequencer #(.aw(4), .dw(32)) dut (
    .clk(clk), .rst(rst), .ld_issue(ld_issue), .fifo_ce_r(fifo_ce_r),
    .fifo_secure(fifo_secure), .mem_ack(mem_ack), .mem_dat(mem_dat),
    .mem_stall(mem_stall), .dec_req(dec_req), .dec_dat_o(dec_dat_o),
    .dec_ack(dec_ack), .dec_dat_i(dec_dat_i), .wb_valid(wb_valid),
    .wb_dat(wb_dat), .wb_secure(wb_secure), .outstanding(outstanding),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        ack;
    logic [31:0] mdat;
    logic        fsec;
    logic        dack;
    logic [31:0] ddat;
    logic        ce;
    logic        stall;
    logic        dreq;
    logic [31:0] ddo;
    logic        wbv;
    logic [31:0] wbd;
    logic        wbs;
    logic [4:0]  outs;
    logic        err;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic ld, logic ack, logic [31:0] mdat, logic fsec,
                              logic dack, logic [31:0] ddat, logic ce, logic stall,
                              logic dreq, logic [31:0] ddo, logic wbv, logic [31:0] wbd,
                              logic wbs, logic [4:0] outs, logic e);
    vec_t v;
    v.ld = ld; v.ack = ack; v.mdat = mdat; v.fsec = fsec; v.dack = dack; v.ddat = ddat;
    v.ce = ce; v.stall = stall; v.dreq = dreq; v.ddo = ddo; v.wbv = wbv; v.wbd = wbd;
    v.wbs = wbs; v.outs = outs; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle
  task automatic set_in(input logic ld, input logic ack, input logic [31:0] mdat,
                        input logic fsec, input logic dack, input logic [31:0] ddat);
    @(negedge clk);
    ld_issue = ld; mem_ack = ack; mem_dat = mdat;
    fifo_secure = fsec; dec_ack = dack; dec_dat_i = ddat;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ld_issue = 0; mem_ack = 0; mem_dat = '0; fifo_secure = 0; dec_ack = 0; dec_dat_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int wb_seen;
    // ld ack mdat fsec dack ddat | ce stall dreq ddo wbv wbd wbs outs err
    vecs[0]  = mk(0,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'h0,0,5'd0,0);
    vecs[1]  = mk(1,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'h0,0,5'd0,0);
    vecs[2]  = mk(1,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'h0,0,5'd1,0);
    vecs[3]  = mk(1,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'h0,0,5'd2,0);
    vecs[4]  = mk(0,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'h0,0,5'd3,0);
    vecs[5]  = mk(0,1,32'hA,0,0,32'h0,         1,0,0,32'h0,0,32'h0,0,5'd3,0);
    vecs[6]  = mk(0,0,32'h0,0,0,32'h0,         0,1,0,32'h0,0,32'h0,0,5'd2,0);
    vecs[7]  = mk(0,0,32'h0,0,0,32'h0,         0,1,0,32'h0,1,32'hA,0,5'd2,0);
    vecs[8]  = mk(0,1,32'hB,0,0,32'h0,         1,0,0,32'h0,0,32'hA,0,5'd2,0);
    vecs[9]  = mk(0,0,32'h0,1,0,32'h0,         0,1,0,32'h0,0,32'hA,0,5'd1,0);
    vecs[10] = mk(0,0,32'h0,0,0,32'h0,         0,1,1,32'hB,0,32'hA,0,5'd1,0);
    vecs[11] = mk(0,0,32'h0,0,0,32'h0,         0,1,1,32'hB,0,32'hA,0,5'd1,0);
    vecs[12] = mk(0,0,32'h0,0,0,32'h0,         0,1,1,32'hB,0,32'hA,0,5'd1,0);
    vecs[13] = mk(0,0,32'h0,0,1,32'hFFFFFFF4,  0,1,1,32'hB,0,32'hA,0,5'd1,0);
    vecs[14] = mk(0,0,32'h0,0,0,32'h0,         0,1,0,32'h0,1,32'hFFFFFFF4,1,5'd1,0);
    vecs[15] = mk(0,1,32'hC,0,0,32'h0,         1,0,0,32'h0,0,32'hFFFFFFF4,0,5'd1,0);
    vecs[16] = mk(0,0,32'h0,0,0,32'h0,         0,1,0,32'h0,0,32'hFFFFFFF4,0,5'd0,0);
    vecs[17] = mk(0,0,32'h0,0,0,32'h0,         0,1,0,32'h0,1,32'hC,0,5'd0,0);
    vecs[18] = mk(0,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'hC,0,5'd0,0);
    vecs[19] = mk(0,1,32'h55,0,0,32'h0,        0,0,0,32'h0,0,32'hC,0,5'd0,0);
    vecs[20] = mk(0,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'hC,0,5'd0,1);
    vecs[21] = mk(0,0,32'h0,0,0,32'h0,         0,0,0,32'h0,0,32'hC,0,5'd0,1);

    do_reset();
    // Reset state, sampled before any edge has moved it
    #1;
    chk("rst_outstanding", {27'b0, outstanding}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_dec_dat_o", dec_dat_o, 32'd0);
    chk("rst_wb_dat", wb_dat, 32'd0);

    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i].ld, vecs[i].ack, vecs[i].mdat, vecs[i].fsec, vecs[i].dack, vecs[i].ddat);
      chk($sformatf("v%0d_fifo_ce_r", i), {31'b0, fifo_ce_r}, {31'b0, vecs[i].ce});
      chk($sformatf("v%0d_mem_stall", i), {31'b0, mem_stall}, {31'b0, vecs[i].stall});
      chk($sformatf("v%0d_dec_req", i), {31'b0, dec_req}, {31'b0, vecs[i].dreq});
      if (vecs[i].dreq) chk($sformatf("v%0d_dec_dat_o", i), dec_dat_o, vecs[i].ddo);
      chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].wbv});
      chk($sformatf("v%0d_wb_dat", i), wb_dat, vecs[i].wbd);
      chk($sformatf("v%0d_wb_secure", i), {31'b0, wb_secure}, {31'b0, vecs[i].wbs});
      chk($sformatf("v%0d_outstanding", i), {27'b0, outstanding}, {27'b0, vecs[i].outs});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
    end

    // Full boundary: 16 issues fill, coincident issue+pop holds, 17th overflows
    do_reset();
    for (int i = 0; i < 16; i++) set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("full_outstanding", {27'b0, outstanding}, 32'd16);
    chk("full_flag", {31'b0, full}, 32'd1);
    chk("full_err", {31'b0, err}, 32'd0);
    set_in(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0);
    chk("coinc_fifo_ce_r", {31'b0, fifo_ce_r}, 32'd1);
    idle();
    chk("coinc_outstanding", {27'b0, outstanding}, 32'd16);
    chk("coinc_err", {31'b0, err}, 32'd0);
    idle();
    chk("coinc_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("coinc_wb_dat", wb_dat, 32'h77);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("ovf_outstanding", {27'b0, outstanding}, 32'd16);
    chk("ovf_err", {31'b0, err}, 32'd1);
    idle();
    chk("ovf_err_sticky", {31'b0, err}, 32'd1);

    // Asynchronous reset while a decryption request is pending
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    chk("rstdec_pre_dec_req", {31'b0, dec_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstdec_dec_req", {31'b0, dec_req}, 32'd0);
    chk("rstdec_mem_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstdec_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rstdec_outstanding", {27'b0, outstanding}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (wb_valid || dec_req) wb_seen++;
    end
    chk("rstdec_quiet_after", wb_seen, 32'd0);

    // Stray mem_ack during decryption is flagged and ignored
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    set_in(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    chk("stray_dec_req", {31'b0, dec_req}, 32'd1);
    chk("stray_fifo_ce_r", {31'b0, fifo_ce_r}, 32'd0);
    idle();
    chk("stray_err", {31'b0, err}, 32'd1);
    chk("stray_dec_dat_o", dec_dat_o, 32'h12345678);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEDCBA987);
    chk("stray_dec_req_hold", {31'b0, dec_req}, 32'd1);
    idle();
    chk("stray_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("stray_wb_dat", wb_dat, 32'hEDCBA987);
    chk("stray_wb_secure", {31'b0, wb_secure}, 32'd1);
    idle();
    chk("stray_dec_req_low", {31'b0, dec_req}, 32'd0);
    chk("stray_wb_valid_low", {31'b0, wb_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
